// File: rtl/memory_unit.sv
// memory_unit: word-addressed main memory behind the CPU core's single bus,
// with a host-side block loader (valid/ready) that owns the array while a
// load runs. CPU accesses refused during a load are counted.
module memory_unit #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  input  logic              mem_en,
  input  logic              mem_cs,
  output logic              mem_busy,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic              ld_valid,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [7:0]        drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               in_load;
  logic               cpu_rd;
  logic               cpu_wr;
  logic               ld_acc;
  logic               ld_last;
  logic [ADDR_W-1:0]  ld_addr;
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [WIDTH-1:0]   wdata;

  // The loader owns the array for the whole LOAD state, stalls included.
  assign in_load  = (state == LOAD);
  assign mem_busy = in_load;
  assign ld_ready = in_load;
  assign ld_done  = (state == DONE);

  assign cpu_rd  = !in_load && mem_en && !mem_cs;
  assign cpu_wr  = !in_load && mem_en &&  mem_cs;
  assign ld_acc  = in_load && ld_valid;
  assign ld_last = (idx_q == len_q - LEN_W'(1));
  // Wraps naturally modulo the array depth.
  assign ld_addr = base_q + ADDR_W'(idx_q);

  // Single write port: loader and CPU are mutually exclusive by state.
  always_comb begin
    we    = 1'b0;
    waddr = addr;
    wdata = data_in;
    if (ld_acc) begin
      we    = 1'b1;
      waddr = ld_addr;
      wdata = ld_data;
    end else if (cpu_wr) begin
      we = 1'b1;
    end
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // CPU read port: one-cycle latency, holds between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      data_out <= '0;
    else if (cpu_rd) data_out <= mem[addr];
  end

  // Saturating count of CPU accesses refused while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (in_load && mem_en && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  // Loader FSM: IDLE -> LOAD (len!=0) or straight to DONE (len==0) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_start) begin
            if (ld_len != '0) begin
              base_q <= ld_base;
              len_q  <= ld_len;
              idx_q  <= '0;
              state  <= LOAD;
            end else begin
              state  <= DONE;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            idx_q <= idx_q + LEN_W'(1);
            if (ld_last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written saturation and
// mid-load reset sequences.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = '0;
  logic [23:0] data_in = '0;
  logic [23:0] data_out;
  logic        mem_en = 1'b0;
  logic        mem_cs = 1'b0;
  logic        mem_busy;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_base = '0;
  logic [7:0]  ld_len = '0;
  logic        ld_valid = 1'b0;
  logic [23:0] ld_data = '0;
  logic        ld_ready;
  logic        ld_done;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  memory_unit #(.WIDTH(24), .ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .mem_en(mem_en), .mem_cs(mem_cs),
    .mem_busy(mem_busy), .ld_start(ld_start), .ld_base(ld_base),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en, cs;
    logic [7:0]  a;
    logic [23:0] d;
    logic        st;
    logic [7:0]  b, l;
    logic        v;
    logic [23:0] ld;
    logic [23:0] e_dout;
    logic        e_busy, e_rdy, e_done;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic en, logic cs, logic [7:0] a,
                              logic [23:0] d, logic st, logic [7:0] b,
                              logic [7:0] l, logic v, logic [23:0] ld,
                              logic [23:0] eo, logic eb, logic er, logic ed,
                              logic [7:0] edr);
    vec_t t;
    t.name = n; t.en = en; t.cs = cs; t.a = a; t.d = d; t.st = st;
    t.b = b; t.l = l; t.v = v; t.ld = ld; t.e_dout = eo; t.e_busy = eb;
    t.e_rdy = er; t.e_done = ed; t.e_drop = edr;
    return t;
  endfunction

  task automatic check(string n, logic [23:0] eo, logic eb, logic er,
                       logic ed, logic [7:0] edr);
    tests++;
    if (data_out !== eo || mem_busy !== eb || ld_ready !== er ||
        ld_done !== ed || drop_cnt !== edr) begin
      fails++;
      $display("FAIL %s: got dout=%h busy=%b rdy=%b done=%b drop=%0d, want dout=%h busy=%b rdy=%b done=%b drop=%0d",
               n, data_out, mem_busy, ld_ready, ld_done, drop_cnt,
               eo, eb, er, ed, edr);
    end
  endtask

  task automatic drive(logic en, logic cs, logic [7:0] a, logic [23:0] d,
                       logic st, logic [7:0] b, logic [7:0] l, logic v,
                       logic [23:0] ld);
    @(negedge clk);
    mem_en = en; mem_cs = cs; addr = a; data_in = d; ld_start = st;
    ld_base = b; ld_len = l; ld_valid = v; ld_data = ld;
  endtask

  task automatic step(logic en, logic cs, logic [7:0] a, logic [23:0] d,
                      logic st, logic [7:0] b, logic [7:0] l, logic v,
                      logic [23:0] ld);
    drive(en, cs, a, d, st, b, l, v, ld);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Load base=20 len=4 with continuous valid
    tbl.push_back(mk("ld20_start", 0,0,0,0, 1,20,4, 0,0,        0,1,1,0,0));
    tbl.push_back(mk("ld20_w1",    0,0,0,0, 0,0,0,  1,24'h1,    0,1,1,0,0));
    tbl.push_back(mk("ld20_w2",    0,0,0,0, 0,0,0,  1,24'h2,    0,1,1,0,0));
    tbl.push_back(mk("ld20_w3",    0,0,0,0, 0,0,0,  1,24'h3,    0,1,1,0,0));
    tbl.push_back(mk("ld20_w4",    0,0,0,0, 0,0,0,  1,24'h4,    0,0,0,1,0));
    tbl.push_back(mk("rd20",       1,0,20,0,0,0,0,  0,0,        24'h1,0,0,0,0));
    tbl.push_back(mk("rd21",       1,0,21,0,0,0,0,  0,0,        24'h2,0,0,0,0));
    tbl.push_back(mk("rd22",       1,0,22,0,0,0,0,  0,0,        24'h3,0,0,0,0));
    tbl.push_back(mk("rd23",       1,0,23,0,0,0,0,  0,0,        24'h4,0,0,0,0));
    // CPU write/read
    tbl.push_back(mk("wr7",        1,1,7,24'hABCDEF,0,0,0,0,0,  24'h4,0,0,0,0));
    tbl.push_back(mk("rd7",        1,0,7,0,0,0,0,  0,0,         24'hABCDEF,0,0,0,0));
    tbl.push_back(mk("wr5",        1,1,5,24'h555555,0,0,0,0,0,  24'hABCDEF,0,0,0,0));
    // Start load together with a CPU read; then refused accesses
    tbl.push_back(mk("st_rd20",    1,0,20,0,1,100,2,0,0,        24'h1,1,1,0,0));
    tbl.push_back(mk("drop_rd1",   1,0,5,0,0,0,0,  0,0,         24'h1,1,1,0,1));
    tbl.push_back(mk("drop_rd2",   1,0,5,0,0,0,0,  0,0,         24'h1,1,1,0,2));
    tbl.push_back(mk("drop_rd3",   1,0,5,0,0,0,0,  0,0,         24'h1,1,1,0,3));
    tbl.push_back(mk("drop_wr5",   1,1,5,24'h123456,0,0,0,0,0,  24'h1,1,1,0,4));
    tbl.push_back(mk("ld100_w1",   0,0,0,0,0,0,0,  1,24'h111111,24'h1,1,1,0,4));
    tbl.push_back(mk("ld100_w2",   0,0,0,0,0,0,0,  1,24'h222222,24'h1,0,0,1,4));
    tbl.push_back(mk("rd5_kept",   1,0,5,0,0,0,0,  0,0,         24'h555555,0,0,0,4));
    tbl.push_back(mk("rd100",      1,0,100,0,0,0,0,0,0,         24'h111111,0,0,0,4));
    tbl.push_back(mk("rd101",      1,0,101,0,0,0,0,0,0,         24'h222222,0,0,0,4));
    // Wrapping load base=254 len=4, valid toggling
    tbl.push_back(mk("wr_start",   0,0,0,0,1,254,4,0,0,         24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_v1",      0,0,0,0,0,0,0,  1,24'hA00001,24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_s1",      0,0,0,0,1,9,9,  0,0,         24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_v2",      0,0,0,0,0,0,0,  1,24'hA00002,24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_s2",      0,0,0,0,0,0,0,  0,0,         24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_v3",      0,0,0,0,0,0,0,  1,24'hA00003,24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_s3",      0,0,0,0,0,0,0,  0,0,         24'h222222,1,1,0,4));
    tbl.push_back(mk("wr_v4",      0,0,0,0,0,0,0,  1,24'hA00004,24'h222222,0,0,1,4));
    tbl.push_back(mk("wr_idle",    0,0,0,0,0,0,0,  0,0,         24'h222222,0,0,0,4));
    tbl.push_back(mk("rd254",      1,0,254,0,0,0,0,0,0,         24'hA00001,0,0,0,4));
    tbl.push_back(mk("rd255",      1,0,255,0,0,0,0,0,0,         24'hA00002,0,0,0,4));
    tbl.push_back(mk("rd0",        1,0,0,0,0,0,0,  0,0,         24'hA00003,0,0,0,4));
    tbl.push_back(mk("rd1",        1,0,1,0,0,0,0,  0,0,         24'hA00004,0,0,0,4));
    // Zero-length load: DONE next edge, no writes even with valid high
    tbl.push_back(mk("z_start",    0,0,0,0,1,7,0,  1,24'hBAD,   24'hA00004,0,0,1,4));
    tbl.push_back(mk("z_idle",     0,0,0,0,0,0,0,  1,24'hBAD,   24'hA00004,0,0,0,4));
    tbl.push_back(mk("z_rd7",      1,0,7,0,0,0,0,  0,0,         24'hABCDEF,0,0,0,4));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].cs, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].b,
           tbl[i].l, tbl[i].v, tbl[i].ld);
      check(tbl[i].name, tbl[i].e_dout, tbl[i].e_busy, tbl[i].e_rdy,
            tbl[i].e_done, tbl[i].e_drop);
    end

    // Saturation: hold mem_en through 300 stalled load cycles
    step(0,0,0,0, 1,200,1, 0,0);
    check("sat_start", 24'hABCDEF, 1, 1, 0, 4);
    for (int k = 1; k <= 300; k++) begin
      step(1,0,3,0, 0,0,0, 0,0);
      if (k == 250) check("sat_250", 24'hABCDEF, 1, 1, 0, 254);
      if (k == 251) check("sat_251", 24'hABCDEF, 1, 1, 0, 255);
    end
    check("sat_300", 24'hABCDEF, 1, 1, 0, 255);
    step(0,0,0,0, 0,0,0, 1,24'h0C0FFE);
    check("sat_done", 24'hABCDEF, 0, 0, 1, 255);
    step(1,0,200,0, 0,0,0, 0,0);
    check("rd200", 24'h0C0FFE, 0, 0, 0, 255);

    // Reset after 2 of 5 words
    step(0,0,0,0, 1,30,5, 0,0);
    step(0,0,0,0, 0,0,0, 1,24'h0000C1);
    step(0,0,0,0, 0,0,0, 1,24'h0000C2);
    check("rl_mid", 24'h0C0FFE, 1, 1, 0, 255);
    @(negedge clk);
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rl_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0,0,0,0, 0,0,0, 0,0);
      check("rl_idle", 0, 0, 0, 0, 0);
    end
    step(1,0,30,0, 0,0,0, 0,0);
    check("rl_rd30", 24'h0000C1, 0, 0, 0, 0);
    step(1,0,31,0, 0,0,0, 0,0);
    check("rl_rd31", 24'h0000C2, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
